clk_step_ctrl: RTL and testbench

- Fast-domain counterpart to the ripple clock divider. The pipeline stays on the single board clock and advances on one-cycle `tick` enables instead of on a derived slow clock.
- Two modes:
  - Free-run: tick every 2^DIV_WIDTH cycles.
  - Single-step: one tick per debounced push-button press.
- Drives the pipeline register enables and a phase LED.

---
 rtl/clk_step_ctrl.sv | 149 ++++++++++++++
 tb/tb_clk_step_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// Single-clock step/run controller: emits one-cycle pipeline enables from a free-running divider or a debounced button.
// Optional TICK_COUNT_EN adds a 16-bit wrap-around count of emitted ticks.
module clk_step_ctrl #(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step_btn,
    output logic        tick,
    output logic        phase,
    output logic        step_busy
`ifdef TICK_COUNT_EN
    ,
    output logic [15:0] tick_count
`endif
);

    localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic                 r_run_s1;
    logic                 r_run_s;
    logic                 r_btn_s1;
    logic                 r_btn_s;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DCNT_W-1:0]    r_dcnt;
    state_t               r_state;
    logic                 r_busy;
    logic                 r_tick;

    logic                 w_run_tick;
    logic                 w_press_done;
    logic                 w_step_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_s1 <= 1'b0;
            r_run_s  <= 1'b0;
            r_btn_s1 <= 1'b0;
            r_btn_s  <= 1'b0;
        end else begin
            r_run_s1 <= run_mode;
            r_run_s  <= r_run_s1;
            r_btn_s1 <= step_btn;
            r_btn_s  <= r_btn_s1;
        end
    end

    // Leaving run mode parks the divider at zero so re-entry always gives a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_run_s) begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_run_tick   = r_run_s & (&r_cnt);
    assign w_press_done = (r_state == PRESS_WAIT) & r_btn_s & (r_dcnt == DCNT_MAX);
    assign w_step_tick  = w_press_done & ~r_run_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_btn_s) begin
                        r_state <= PRESS_WAIT;
                        r_dcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_btn_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_dcnt == DCNT_MAX) begin
                        r_state <= PRESSED;
                    end else begin
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!r_btn_s) begin
                        r_state <= RELEASE_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high resumes the held state without a second step.
                    if (r_btn_s) begin
                        r_state <= PRESSED;
                    end else if (r_dcnt == DCNT_MAX) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_dcnt  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_run_tick | w_step_tick;
        end
    end

`ifdef TICK_COUNT_EN
    logic [15:0] r_tick_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_count <= '0;
        end else if (r_tick) begin
            r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign tick_count = r_tick_count;
`endif

    assign tick      = r_tick;
    assign phase     = r_cnt[DIV_WIDTH-1];
    assign step_busy = r_busy;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: expected tick edges are queued at stimulus time and matched as ticks appear.
module tb_clk_step_ctrl;

    localparam int DW = 4;
    localparam int DB = 5;

    logic clk = 1'b0;
    logic reset;
    logic run_mode;
    logic step_btn;
    logic tick;
    logic phase;
    logic step_busy;
`ifdef TICK_COUNT_EN
    logic [15:0] tick_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int exp_q[$];
    int exp_tc   = 0;
    bit mon_en   = 1'b0;

    clk_step_ctrl #(
        .DIV_WIDTH      (DW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .tick     (tick),
        .phase    (phase),
        .step_busy(step_busy)
`ifdef TICK_COUNT_EN
        ,
        .tick_count(tick_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    // Each tick must land on exactly the edge queued for it; extra ticks fail.
    always @(negedge clk) begin
        if (mon_en && tick === 1'b1) begin
            if (exp_q.size() == 0) chk("tick_unexpected", edge_n, -1);
            else chk("tick_edge", edge_n, exp_q.pop_front());
        end
    end

    task automatic push_tick(input int e);
        exp_q.push_back(e);
        exp_tc++;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_apply();
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_tc = 0;
        chk("rst_tick", tick, 0);
        chk("rst_phase", phase, 0);
        chk("rst_busy", step_busy, 0);
`ifdef TICK_COUNT_EN
        chk("rst_tick_count", tick_count, 0);
`endif
    endtask

    task automatic rst_release(output int r);
        @(negedge clk);
        reset = 1'b0;
        r = edge_n;
    endtask

    task automatic check_drained(input string tag);
        #1;
        chk(tag, exp_q.size(), 0);
`ifdef TICK_COUNT_EN
        chk({tag, "_count"}, tick_count, exp_tc);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        int e0;
        int f0;
        int s;
        int k;
        int cnt_exp;

        reset    = 1'b1;
        run_mode = 1'b0;
        step_btn = 1'b0;
        wait_neg(3);
        #1;
        chk("init_tick", tick, 0);
        chk("init_phase", phase, 0);
        chk("init_busy", step_busy, 0);
        mon_en = 1'b1;

        // Free-run: run_s rises after release edge r+2; ticks follow the 16th, 32nd, 48th edges after that.
        run_mode = 1'b1;
        rst_release(r);
        push_tick(r + 18);
        push_tick(r + 34);
        push_tick(r + 50);
        for (int j = 1; j <= 52; j++) begin
            @(negedge clk);
            k = j - 2;
            cnt_exp = (k < 0) ? 0 : (k % 16);
            chk("run_phase", phase, (cnt_exp >= 8) ? 1 : 0);
        end
        check_drained("run_missing");

        // Reset in the middle of a run with a press being swallowed by run mode.
        rst_apply();
        step_btn = 1'b1;
        rst_release(r);
        wait_neg(12);
        chk("mid_phase_before", phase, 1);
        chk("mid_busy_before", step_busy, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_busy", step_busy, 0);
        chk("mid_rst_queue", exp_q.size(), 0);
        exp_tc   = 0;
        step_btn = 1'b0;
        rst_release(r);
        push_tick(r + 18);
        wait_neg(20);
        check_drained("mid_after_missing");

        // Clean step press held 20 cycles.
        rst_apply();
        run_mode = 1'b0;
        rst_release(r);
        wait_neg(4);
        step_btn = 1'b1;
        e0 = edge_n + 1;
        push_tick(e0 + DB + 2);
        wait_neg(2);
        chk("press_busy_early", step_busy, 0);
        wait_neg(1);
        chk("press_busy_on", step_busy, 1);
        wait_neg(17);
        chk("press_busy_held", step_busy, 1);
        chk("step_phase", phase, 0);
        step_btn = 1'b0;
        f0 = edge_n + 1;
        wait_neg(7);
        chk("release_busy_hold", step_busy, 1);
        wait_neg(1);
        chk("release_busy_off", step_busy, 0);
        check_drained("press_missing");

        // Short glitches never qualify as a press.
        for (int g = 1; g <= 4; g++) begin
            step_btn = 1'b1;
            e0 = edge_n + 1;
            wait_neg(g);
            step_btn = 1'b0;
            while (edge_n < e0 + 2) @(negedge clk);
            chk($sformatf("glitch%0d_busy_on", g), step_busy, 1);
            wait_neg(12);
            chk($sformatf("glitch%0d_busy_off", g), step_busy, 0);
        end
        check_drained("glitch_missing");

        // Clean press then a bouncy release: one tick only.
        step_btn = 1'b1;
        e0 = edge_n + 1;
        push_tick(e0 + DB + 2);
        wait_neg(10);
        step_btn = 1'b0;
        wait_neg(2);
        step_btn = 1'b1;
        wait_neg(3);
        step_btn = 1'b0;
        wait_neg(2);
        chk("bounce_busy_mid", step_busy, 1);
        step_btn = 1'b1;
        wait_neg(3);
        step_btn = 1'b0;
        f0 = edge_n + 1;
        wait_neg(7);
        chk("bounce_busy_hold", step_busy, 1);
        wait_neg(1);
        chk("bounce_busy_off", step_busy, 0);
        check_drained("bounce_missing");

        // Step -> run -> step: three run ticks then one step tick.
        rst_apply();
        run_mode = 1'b0;
        rst_release(r);
        wait_neg(3);
        run_mode = 1'b1;
        s = edge_n + 1;
        push_tick(s + 17);
        push_tick(s + 33);
        push_tick(s + 49);
        while (edge_n < s + 50) @(negedge clk);
        run_mode = 1'b0;
        wait_neg(6);
        chk("switch_phase", phase, 0);
        step_btn = 1'b1;
        e0 = edge_n + 1;
        push_tick(e0 + DB + 2);
        wait_neg(10);
        step_btn = 1'b0;
        wait_neg(10);
        check_drained("switch_missing");
        chk("switch_total_ticks", exp_tc, 4);
        rst_apply();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
